// File: rtl/bcd_to_bin_seq_pkg.sv
// rtl/bcd_to_bin_seq_pkg.sv - shared score width helpers for the BCD/binary converters
package bcd_to_bin_seq_pkg;

   // BCD width able to hold any W-bit binary value, used by both conversion directions.
   function automatic int bcd_width(input int w);
      return w + (w - 4) / 3 + 1;
   endfunction

   function automatic int bcd_digits(input int w);
      return (bcd_width(w) + 3) / 4;
   endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - reverse double dabble digit correction
module bcd_digit_sub3 (
   input  logic [3:0] d,
   output logic [3:0] q
);

   assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD to binary converter, one shift per clock
module bcd_to_bin_seq
   import bcd_to_bin_seq_pkg::*;
#(
   parameter  int W  = 16,
   localparam int BW = bcd_width(W),
   localparam int ND = bcd_digits(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [BW-1:0] bcd_in,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  bin,
   output logic          ovf,
   output logic          err
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t          state;
   logic [4*ND-1:0] bcd_reg;
   logic [W-1:0]    bin_reg;
   logic [CW-1:0]   count;
   logic            err_pending;

   logic [4*ND-1:0] bcd_pad;
   logic [4*ND-1:0] sh_bcd;
   logic [4*ND-1:0] corr_bcd;
   logic [W-1:0]    sh_bin;
   logic            bad_digit;

   assign bcd_pad = (4*ND)'(bcd_in);

   // The whole scratch shifts right as one vector; the bit leaving bcd_reg lands in bin_reg's MSB.
   assign {sh_bcd, sh_bin} = {1'b0, bcd_reg, bin_reg[W-1:1]};

   for (genvar i = 0; i < ND; i++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
         .d(sh_bcd[4*i +: 4]),
         .q(corr_bcd[4*i +: 4])
      );
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < ND; i++) begin
         if (bcd_pad[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bcd_reg     <= '0;
         bin_reg     <= '0;
         count       <= '0;
         err_pending <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         bin         <= '0;
         ovf         <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_reg     <= bcd_pad;
                  bin_reg     <= '0;
                  err_pending <= bad_digit;
                  ovf         <= 1'b0;
                  err         <= 1'b0;
                  count       <= '0;
                  busy        <= 1'b1;
                  state       <= bad_digit ? FIN : SHIFT;
               end
            end
            SHIFT: begin
               bcd_reg <= corr_bcd;
               bin_reg <= sh_bin;
               count   <= count + 1'b1;
               if (count == LAST) state <= FIN;
            end
            FIN: begin
               // Anything left in bcd_reg after W shifts is value above 2^W-1.
               done  <= 1'b1;
               busy  <= 1'b0;
               bin   <= err_pending ? '0 : bin_reg;
               ovf   <= (bcd_reg != '0) && !err_pending;
               err   <= err_pending;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
   import bcd_to_bin_seq_pkg::*;

   localparam int W  = 16;
   localparam int BW = bcd_width(W);
   localparam int ND = bcd_digits(W);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [BW-1:0] bcd_in = '0;
   logic          busy, done, ovf, err;
   logic [W-1:0]  bin;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   bcd_to_bin_seq #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
      .busy(busy), .done(done), .bin(bin), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal interpretation of the digits, then plain range arithmetic.
   task automatic model(input logic [BW-1:0] v, output logic [W-1:0] b,
                        output logic o, output logic e);
      logic [4*ND-1:0] pv;
      longint val;
      longint p;
      pv  = (4*ND)'(v);
      val = 0;
      p   = 1;
      e   = 1'b0;
      for (int i = 0; i < ND; i++) begin
         if (pv[4*i +: 4] > 4'd9) e = 1'b1;
         val += longint'(pv[4*i +: 4]) * p;
         p   *= 10;
      end
      if (e) begin
         b = '0;
         o = 1'b0;
      end else begin
         b = W'(val);
         o = (val > ((longint'(1) << W) - 1));
      end
   endtask

   task automatic run_conv(input logic [BW-1:0] v);
      logic [W-1:0] eb;
      logic eo, ee;
      int k, bc;
      model(v, eb, eo, ee);
      @(negedge clk);
      bcd_in = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = BW'($urandom);
      k  = 0;
      bc = 0;
      while (!done && k < 40) begin
         if (busy) bc++;
         @(negedge clk);
         k++;
      end
      check("latency", k, ee ? 1 : W + 1);
      check("busy_cycles", bc, ee ? 1 : W + 1);
      check("bin", 32'(bin), 32'(eb));
      check("ovf", 32'(ovf), 32'(eo));
      check("err", 32'(err), 32'(ee));
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("bin_hold", 32'(bin), 32'(eb));
   endtask

   initial begin
      logic [W-1:0] eb;
      logic eo, ee;
      logic [BW-1:0] v;
      int ndone, t1, t2;
      logic [W-1:0] seen_bin;

      #1;
      check("reset_outputs", {busy, done, ovf, err, bin}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_conv(BW'(20'h12345));
      run_conv(BW'(20'h65535));
      run_conv(BW'(20'h00000));
      run_conv(BW'(20'h65536));
      run_conv(BW'(20'h99999));
      run_conv(BW'(20'h0A123));

      for (int n = 0; n < 12; n++) begin
         v = '0;
         for (int i = 0; i < 5; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
         run_conv(v);
      end
      for (int n = 0; n < 4; n++) run_conv(BW'($urandom) & BW'(20'hFFFFF));

      // A second start during SHIFT must be dropped.
      model(BW'(20'h00042), eb, eo, ee);
      @(negedge clk);
      bcd_in = BW'(20'h00042);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      bcd_in = BW'(20'h00001);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      ndone    = 0;
      seen_bin = '0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin
            ndone++;
            seen_bin = bin;
         end
         @(negedge clk);
      end
      check("ignore_start_ndone", ndone, 1);
      check("ignore_start_bin", 32'(seen_bin), 32'(eb));

      // Start held high: back-to-back conversions.
      model(BW'(20'h00007), eb, eo, ee);
      bcd_in = BW'(20'h00007);
      start  = 1'b1;
      ndone  = 0;
      t1     = 0;
      t2     = 0;
      for (int c = 0; c < 80 && ndone < 2; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) t1 = c;
            else t2 = c;
            check("b2b_bin", 32'(bin), 32'(eb));
         end
      end
      start = 1'b0;
      check("b2b_ndone", ndone, 2);
      check("b2b_spacing", t2 - t1, W + 2);

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      bcd_in = BW'(20'h12345);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {busy, done, ovf, err, bin}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      check("no_done_after_reset", ndone, 0);
      run_conv(BW'(20'h00100));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
